// File: rtl/spider_motion_ctrl_if.sv
// rtl/spider_motion_ctrl_if.sv - frame/hit inputs and sprite state outputs of one spider
interface spider_motion_ctrl_if;
    logic       frame_tick;
    logic       hit;
    logic [9:0] spider_x;
    logic [9:0] spider_y;
    logic       spider_alive;
    logic       killed;
    logic       reached_bottom;

    modport master (
        output frame_tick, hit,
        input  spider_x, spider_y, spider_alive, killed, reached_bottom
    );

    modport slave (
        input  frame_tick, hit,
        output spider_x, spider_y, spider_alive, killed, reached_bottom
    );
endinterface

// File: rtl/spider_motion_ctrl.sv
// rtl/spider_motion_ctrl.sv - spider sweep/bounce/step-down motion with kill and respawn timer
// Optional feature macro: SPIDER_SPEEDUP_EN (speed grows by one on each respawn after a kill).
module spider_motion_ctrl #(
    parameter int X_START        = 0,
    parameter int Y_START        = 32,
    parameter int X_MIN          = 0,
    parameter int X_MAX          = 608,
    parameter int Y_STEP         = 16,
    parameter int Y_LIMIT        = 448,
    parameter int SPEED          = 2,
    parameter int MAX_SPEED      = 8,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic                 clk,
    input  logic                 rst,
    spider_motion_ctrl_if.slave  bus
);
    typedef enum logic {MOVE = 1'b0, DEAD = 1'b1} state_t;

    localparam int TW = (RESPAWN_FRAMES < 2) ? 1 : $clog2(RESPAWN_FRAMES + 1);
    // MAX_SPEED is a ceiling on the starting speed as well as on growth.
    localparam int SPEED_INIT = (SPEED > MAX_SPEED) ? MAX_SPEED : SPEED;

    localparam logic [10:0]   X_MIN_W   = 11'(X_MIN);
    localparam logic [10:0]   X_MAX_W   = 11'(X_MAX);
    localparam logic [10:0]   Y_STEP_W  = 11'(Y_STEP);
    localparam logic [10:0]   Y_LIMIT_W = 11'(Y_LIMIT);
    localparam logic [TW-1:0] TIMER_RST = TW'(RESPAWN_FRAMES);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);

    state_t        state_q, state_d;
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic          dir_left_q, dir_left_d;
    logic          alive_q, alive_d;
    logic          killed_q, killed_d;
    logic          bottom_q, bottom_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          step;
    logic [10:0]   x_w, y_w, speed_w;

`ifdef SPIDER_SPEEDUP_EN
    localparam logic [10:0] MAX_SPEED_W = 11'(MAX_SPEED);
    logic [10:0] speed_q, speed_d;
    logic        by_hit_q, by_hit_d;
    assign speed_w = speed_q;
`else
    assign speed_w = 11'(SPEED_INIT);
`endif

    assign x_w = {1'b0, x_q};
    assign y_w = {1'b0, y_q};

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        dir_left_d = dir_left_q;
        alive_d    = alive_q;
        killed_d   = 1'b0;
        bottom_d   = 1'b0;
        timer_d    = timer_q;
        step       = 1'b0;
`ifdef SPIDER_SPEEDUP_EN
        speed_d    = speed_q;
        by_hit_d   = by_hit_q;
`endif
        case (state_q)
            MOVE: begin
                if (bus.hit) begin
                    alive_d  = 1'b0;
                    killed_d = 1'b1;
                    state_d  = DEAD;
                    timer_d  = TIMER_RST;
`ifdef SPIDER_SPEEDUP_EN
                    by_hit_d = 1'b1;
`endif
                end else if (bus.frame_tick) begin
                    if (!dir_left_q) begin
                        if (x_w + speed_w >= X_MAX_W) begin
                            x_d        = X_MAX_W[9:0];
                            dir_left_d = 1'b1;
                            step       = 1'b1;
                        end else begin
                            x_d = 10'(x_w + speed_w);
                        end
                    end else begin
                        if (x_w <= X_MIN_W + speed_w) begin
                            x_d        = X_MIN_W[9:0];
                            dir_left_d = 1'b0;
                            step       = 1'b1;
                        end else begin
                            x_d = 10'(x_w - speed_w);
                        end
                    end
                    if (step) begin
                        if (y_w + Y_STEP_W >= Y_LIMIT_W) begin
                            y_d      = Y_LIMIT_W[9:0];
                            bottom_d = 1'b1;
                            alive_d  = 1'b0;
                            state_d  = DEAD;
                            timer_d  = TIMER_RST;
`ifdef SPIDER_SPEEDUP_EN
                            by_hit_d = 1'b0;
`endif
                        end else begin
                            y_d = 10'(y_w + Y_STEP_W);
                        end
                    end
                end
            end
            DEAD: begin
                if (bus.frame_tick) begin
                    if (timer_q == TIMER_ONE) begin
                        x_d        = 10'(X_START);
                        y_d        = 10'(Y_START);
                        dir_left_d = 1'b0;
                        alive_d    = 1'b1;
                        state_d    = MOVE;
                        timer_d    = '0;
`ifdef SPIDER_SPEEDUP_EN
                        if (by_hit_q && (speed_q < MAX_SPEED_W)) speed_d = speed_q + 11'd1;
`endif
                    end else begin
                        timer_d = timer_q - TIMER_ONE;
                    end
                end
            end
            default: state_d = MOVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MOVE;
            x_q        <= 10'(X_START);
            y_q        <= 10'(Y_START);
            dir_left_q <= 1'b0;
            alive_q    <= 1'b1;
            killed_q   <= 1'b0;
            bottom_q   <= 1'b0;
            timer_q    <= '0;
`ifdef SPIDER_SPEEDUP_EN
            speed_q    <= 11'(SPEED_INIT);
            by_hit_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            dir_left_q <= dir_left_d;
            alive_q    <= alive_d;
            killed_q   <= killed_d;
            bottom_q   <= bottom_d;
            timer_q    <= timer_d;
`ifdef SPIDER_SPEEDUP_EN
            speed_q    <= speed_d;
            by_hit_q   <= by_hit_d;
`endif
        end
    end

    assign bus.spider_x       = x_q;
    assign bus.spider_y       = y_q;
    assign bus.spider_alive   = alive_q;
    assign bus.killed         = killed_q;
    assign bus.reached_bottom = bottom_q;
endmodule

// File: tb/tb_spider_motion_ctrl.sv
// tb/tb_spider_motion_ctrl.sv - directed vector bench for spider_motion_ctrl
module tb_spider_motion_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    spider_motion_ctrl_if bus_a();
    spider_motion_ctrl_if bus_b();

    spider_motion_ctrl dut_a (.clk(clk), .rst(rst_a), .bus(bus_a.slave));
    spider_motion_ctrl #(.Y_LIMIT(64)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b.slave));

`ifdef SPIDER_SPEEDUP_EN
    localparam int X_AFTER_KILL = 30;
`else
    localparam int X_AFTER_KILL = 20;
`endif

    typedef struct {
        string name;
        logic  r, t, h;
        int    n;
        int    x, y, alive, killed, bottom;
    } vec_t;

    vec_t vecs[15];
    int   vec_cnt = 0;
    int   err_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step_a(input logic r, input logic t, input logic h);
        @(negedge clk);
        rst_a = r; bus_a.frame_tick = t; bus_a.hit = h;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic r, input logic t, input logic h);
        @(negedge clk);
        rst_b = r; bus_b.frame_tick = t; bus_b.hit = h;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_b(input string nm, input int x, input int y, input int al, input int k, input int b);
        vec_cnt++;
        chk({nm, ".x"}, int'(bus_b.spider_x), x);
        chk({nm, ".y"}, int'(bus_b.spider_y), y);
        chk({nm, ".alive"}, int'(bus_b.spider_alive), al);
        chk({nm, ".killed"}, int'(bus_b.killed), k);
        chk({nm, ".bottom"}, int'(bus_b.reached_bottom), b);
    endtask

    initial begin
        int bcnt;
        int btick;

        bus_a.frame_tick = 1'b0; bus_a.hit = 1'b0;
        bus_b.frame_tick = 1'b0; bus_b.hit = 1'b0;

        //            name           r     t     h     n    x             y   al k  b
        vecs[0]  = '{"reset",       1'b1, 1'b0, 1'b0, 2,   0,            32, 1, 0, 0};
        vecs[1]  = '{"tick10",      1'b0, 1'b1, 1'b0, 10,  20,           32, 1, 0, 0};
        vecs[2]  = '{"idle_hold",   1'b0, 1'b0, 1'b0, 5,   20,           32, 1, 0, 0};
        vecs[3]  = '{"hit",         1'b0, 1'b0, 1'b1, 1,   20,           32, 0, 1, 0};
        vecs[4]  = '{"kill_1cyc",   1'b0, 1'b0, 1'b0, 1,   20,           32, 0, 0, 0};
        vecs[5]  = '{"dead59",      1'b0, 1'b1, 1'b0, 59,  20,           32, 0, 0, 0};
        vecs[6]  = '{"hit_dead",    1'b0, 1'b0, 1'b1, 1,   20,           32, 0, 0, 0};
        vecs[7]  = '{"respawn60",   1'b0, 1'b1, 1'b0, 1,   0,            32, 1, 0, 0};
        vecs[8]  = '{"post_resp10", 1'b0, 1'b1, 1'b0, 10,  X_AFTER_KILL, 32, 1, 0, 0};
        vecs[9]  = '{"hit_and_tick",1'b0, 1'b1, 1'b1, 1,   X_AFTER_KILL, 32, 0, 1, 0};
        vecs[10] = '{"reset_dead",  1'b1, 1'b0, 1'b0, 1,   0,            32, 1, 0, 0};
        vecs[11] = '{"tick303",     1'b0, 1'b1, 1'b0, 303, 606,          32, 1, 0, 0};
        vecs[12] = '{"right_edge",  1'b0, 1'b1, 1'b0, 1,   608,          48, 1, 0, 0};
        vecs[13] = '{"turn_left",   1'b0, 1'b1, 1'b0, 1,   606,          48, 1, 0, 0};
        vecs[14] = '{"rst_wins",    1'b1, 1'b1, 1'b1, 1,   0,            32, 1, 0, 0};

        for (int i = 0; i < 15; i++) begin
            for (int c = 0; c < vecs[i].n; c++) step_a(vecs[i].r, vecs[i].t, vecs[i].h);
            vec_cnt++;
            chk({vecs[i].name, ".x"}, int'(bus_a.spider_x), vecs[i].x);
            chk({vecs[i].name, ".y"}, int'(bus_a.spider_y), vecs[i].y);
            chk({vecs[i].name, ".alive"}, int'(bus_a.spider_alive), vecs[i].alive);
            chk({vecs[i].name, ".killed"}, int'(bus_a.killed), vecs[i].killed);
            chk({vecs[i].name, ".bottom"}, int'(bus_a.reached_bottom), vecs[i].bottom);
        end
        step_a(1'b0, 1'b0, 1'b0);

        // Shallow playfield: second bounce (at the left edge) lands on the bottom.
        step_b(1'b1, 1'b0, 1'b0);
        step_b(1'b1, 1'b0, 1'b0);
        chk_b("b_reset", 0, 32, 1, 0, 0);
        bcnt = 0;
        btick = 0;
        for (int t = 1; t <= 608; t++) begin
            step_b(1'b0, 1'b1, 1'b0);
            if (bus_b.reached_bottom) begin
                bcnt++;
                btick = t;
            end
            if (t == 607) chk_b("b_tick607", 2, 48, 1, 0, 0);
        end
        vec_cnt++;
        chk("b_bottom_count", bcnt, 1);
        chk("b_bottom_tick", btick, 608);
        chk_b("b_tick608", 0, 64, 0, 0, 1);
        step_b(1'b0, 1'b0, 1'b0);
        chk_b("b_bottom_1cyc", 0, 64, 0, 0, 0);
        step_b(1'b0, 1'b0, 1'b1);
        chk_b("b_hit_dead", 0, 64, 0, 0, 0);
        for (int t = 0; t < 59; t++) step_b(1'b0, 1'b1, 1'b0);
        chk_b("b_dead59", 0, 64, 0, 0, 0);
        step_b(1'b0, 1'b1, 1'b0);
        chk_b("b_respawn", 0, 32, 1, 0, 0);
        // A respawn after reaching the bottom keeps the original speed.
        for (int t = 0; t < 10; t++) step_b(1'b0, 1'b1, 1'b0);
        chk_b("b_post_resp10", 20, 32, 1, 0, 0);
        step_b(1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
